// File: rtl/armleocpu_regfile_pkg.sv
// rtl/armleocpu_regfile_pkg.sv - shared state encodings and port-slice helpers for the multiport regfile
package armleocpu_regfile_pkg;

   typedef enum logic {
      REGFILE_CLEAR = 1'b0,
      REGFILE_RUN   = 1'b1
   } regfile_state_t;

   // Lowest bit of slice `port` inside a packed bus of `slice_w`-wide slices.
   function automatic int port_lsb(input int port, input int slice_w);
      return port * slice_w;
   endfunction

endpackage

// File: rtl/armleocpu_regfile_read_port.sv
// rtl/armleocpu_regfile_read_port.sv - one registered read lane: zero/bypass/storage select and data register
module armleocpu_regfile_read_port
   import armleocpu_regfile_pkg::*;
#(
   parameter int ELEMENTS_W = 5,
   parameter int WIDTH      = 32,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  regfile_state_t        state,
   input  logic                  en,
   input  logic [ELEMENTS_W-1:0] addr,
   input  logic [WIDTH-1:0]      storage_data,
   input  logic                  wr_eff,
   input  logic [ELEMENTS_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   output logic [WIDTH-1:0]      data
);

   logic [WIDTH-1:0] next_data;
   logic             is_zero;
   logic             is_bypass;

   assign is_zero   = (ZERO_REG != 0) && (addr == '0);
   assign is_bypass = (BYPASS != 0) && wr_eff && (wr_addr == addr);

   // Zero entry wins over bypass so a write aimed at entry 0 can never leak through.
   always_comb begin
      next_data = storage_data;
      if (is_zero) begin
         next_data = '0;
      end else if (is_bypass) begin
         next_data = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
      end else if ((state == REGFILE_RUN) && en) begin
         data <= next_data;
      end
   end

endmodule

// File: rtl/armleocpu_regfile_multiport.sv
// rtl/armleocpu_regfile_multiport.sv - multi-read-port register file with one write port and post-reset clear
module armleocpu_regfile_multiport
   import armleocpu_regfile_pkg::*;
#(
   parameter int ELEMENTS_W = 5,
   parameter int WIDTH      = 32,
   parameter int READ_PORTS = 2,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   output logic                             ready,
   input  logic [READ_PORTS-1:0]            rd_en,
   input  logic [READ_PORTS*ELEMENTS_W-1:0] rd_addr,
   output logic [READ_PORTS*WIDTH-1:0]      rd_data,
   input  logic                             wr_en,
   input  logic [ELEMENTS_W-1:0]            wr_addr,
   input  logic [WIDTH-1:0]                 wr_data
);

   localparam int                    ELEMENTS   = 2 ** ELEMENTS_W;
   localparam logic [ELEMENTS_W-1:0] LAST_ENTRY = ELEMENTS_W'(ELEMENTS - 1);

   regfile_state_t        state;
   logic [ELEMENTS_W-1:0] counter;
   logic [WIDTH-1:0]      storage [ELEMENTS];
   logic                  wr_eff;

   assign wr_eff = (state == REGFILE_RUN) && wr_en &&
                   !((ZERO_REG != 0) && (wr_addr == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= REGFILE_CLEAR;
         counter <= '0;
         ready   <= 1'b0;
      end else if (state == REGFILE_CLEAR) begin
         counter <= counter + 1'b1;
         if (counter == LAST_ENTRY) begin
            state <= REGFILE_RUN;
            ready <= 1'b1;
         end
      end
   end

   // Storage carries no reset so it can map onto RAM; the clear engine zeroes it instead.
   always_ff @(posedge clk) begin
      if (state == REGFILE_CLEAR) begin
         storage[counter] <= '0;
      end else if (wr_eff) begin
         storage[wr_addr] <= wr_data;
      end
   end

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
      localparam int ALSB = port_lsb(p, ELEMENTS_W);
      localparam int DLSB = port_lsb(p, WIDTH);

      logic [ELEMENTS_W-1:0] port_addr;
      assign port_addr = rd_addr[ALSB +: ELEMENTS_W];

      armleocpu_regfile_read_port #(
         .ELEMENTS_W (ELEMENTS_W),
         .WIDTH      (WIDTH),
         .ZERO_REG   (ZERO_REG),
         .BYPASS     (BYPASS)
      ) u_port (
         .clk          (clk),
         .rst_n        (rst_n),
         .state        (state),
         .en           (rd_en[p]),
         .addr         (port_addr),
         .storage_data (storage[port_addr]),
         .wr_eff       (wr_eff),
         .wr_addr      (wr_addr),
         .wr_data      (wr_data),
         .data         (rd_data[DLSB +: WIDTH])
      );
   end

endmodule
